// File: rtl/viterbi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : viterbi_pkg                                                   |
// | Purpose  : Shared Viterbi helpers: metric typedefs, parity, state count  |
// |            and the trellis connectivity (predecessor / branch-metric     |
// |            index per next state and input bit).                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package viterbi_pkg;

  // Default metric widths of the decoder build
  localparam int c_bm_w_def = 4;
  localparam int c_pm_w_def = 8;

  typedef logic [c_bm_w_def-1:0] bm_t;
  typedef logic [c_pm_w_def-1:0] pm_t;

  function automatic int n_states(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

  // Predecessor p_b of next state ns: {ns[K-3:0], b}
  function automatic int pred_idx(input int k, input int ns, input int b);
    return ((ns << 1) | b) & (n_states(k) - 1);
  endfunction

  // Branch-metric index j = 2*c0 + c1 for the branch p_b -> ns.
  // The code register is {u, p_b} with u = ns[K-2] (newest bit is the MSB).
  function automatic int bm_idx(input int k, input int g0, input int g1,
                                input int ns, input int b);
    int   u;
    int   code;
    logic c0;
    logic c1;
    u    = (ns >> (k - 2)) & 1;
    code = (u << (k - 1)) | pred_idx(k, ns, b);
    c0   = parity(32'(g0 & code));
    c1   = parity(32'(g1 & code));
    return (c0 ? 2 : 0) + (c1 ? 1 : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/acs_cs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acs_cs                                                        |
// | Purpose  : Compare-select cell for one next state. Adds each branch      |
// |            metric to its predecessor metric with saturation and keeps    |
// |            the smaller candidate; a tie keeps candidate 0.               |
// | Ports    : i_pm0/i_pm1 predecessor metrics, i_bm0/i_bm1 branch metrics,  |
// |            o_sel selected metric, o_dec decision (1 = candidate 1 won).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module acs_cs #(
  parameter int BM_W = 4,
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [BM_W-1:0] i_bm0,
  input  logic [BM_W-1:0] i_bm1,
  output logic [PM_W-1:0] o_sel,
  output logic            o_dec
);

  logic [PM_W:0]   w_sum0;
  logic [PM_W:0]   w_sum1;
  logic [PM_W-1:0] w_cand0;
  logic [PM_W-1:0] w_cand1;

  assign w_sum0 = {1'b0, i_pm0} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm0};
  assign w_sum1 = {1'b0, i_pm1} + {{(PM_W + 1 - BM_W){1'b0}}, i_bm1};

  // Carry out means overflow: clamp to all ones
  assign w_cand0 = w_sum0[PM_W] ? '1 : w_sum0[PM_W-1:0];
  assign w_cand1 = w_sum1[PM_W] ? '1 : w_sum1[PM_W-1:0];

  // Strict compare so equal candidates resolve to b=0
  assign o_dec = (w_cand1 < w_cand0);
  assign o_sel = o_dec ? w_cand1 : w_cand0;

endmodule
`default_nettype wire

// File: rtl/acs_trellis_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acs_trellis_array                                             |
// | Purpose  : Add-compare-select array updating all 2^(K-1) path metrics of |
// |            a rate-1/2 code per accepted branch-metric vector.            |
// | Ports    : clk, rst (async, active-high), start (frame reload),          |
// |            in_valid/bm_i (branch metrics, entry j at [j*BM_W +: BM_W]),  |
// |            out_valid, dec_o (survivor bit per next state),               |
// |            best_state_o / best_pm_o (argmin / min of new metrics).       |
// | Config   : ACS_NORM_EN - subtract min(current metrics) every step.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module acs_trellis_array
  import viterbi_pkg::*;
#(
  parameter int K       = 3,
  parameter int G0      = 7,
  parameter int G1      = 5,
  parameter int BM_W    = 4,
  parameter int PM_W    = 8,
  parameter int INIT_PM = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [4*BM_W-1:0]       bm_i,
  output logic                    out_valid,
  output logic [(1<<(K-1))-1:0]   dec_o,
  output logic [K-2:0]            best_state_o,
  output logic [PM_W-1:0]         best_pm_o
);

  localparam int              c_n_states = n_states(K);
  localparam int              c_sw       = K - 1;
  localparam logic [PM_W-1:0] c_init_pm  = PM_W'(INIT_PM);

  logic [PM_W-1:0]       r_pm [c_n_states];
  logic [PM_W-1:0]       w_sel [c_n_states];
  logic [c_n_states-1:0] w_dec;
  logic [PM_W-1:0]       w_best_pm;
  logic [c_sw-1:0]       w_best_st;
  logic [PM_W-1:0]       w_min_cur;

  logic                  r_out_valid;
  logic [c_n_states-1:0] r_dec;
  logic [c_sw-1:0]       r_best_state;
  logic [PM_W-1:0]       r_best_pm;

  // One compare-select cell per next state; wiring is fixed at elaboration
  for (genvar ns = 0; ns < c_n_states; ns++) begin : g_state
    localparam int c_p0 = pred_idx(K, ns, 0);
    localparam int c_p1 = pred_idx(K, ns, 1);
    localparam int c_j0 = bm_idx(K, G0, G1, ns, 0);
    localparam int c_j1 = bm_idx(K, G0, G1, ns, 1);

    acs_cs #(
      .BM_W (BM_W),
      .PM_W (PM_W)
    ) u_cs (
      .i_pm0 (r_pm[c_p0]),
      .i_pm1 (r_pm[c_p1]),
      .i_bm0 (bm_i[c_j0*BM_W +: BM_W]),
      .i_bm1 (bm_i[c_j1*BM_W +: BM_W]),
      .o_sel (w_sel[ns]),
      .o_dec (w_dec[ns])
    );
  end

  // Argmin over the new metrics; strict compare keeps the lowest index on ties
  always_comb begin
    w_best_pm = w_sel[0];
    w_best_st = '0;
    for (int i = 1; i < c_n_states; i++) begin
      if (w_sel[i] < w_best_pm) begin
        w_best_pm = w_sel[i];
        w_best_st = c_sw'(i);
      end
    end
  end

`ifdef ACS_NORM_EN
  // Min over registered metrics only, so it runs in parallel with the ACS.
  // Every candidate is >= its predecessor metric >= this min, so the
  // subtraction never underflows.
  always_comb begin
    w_min_cur = r_pm[0];
    for (int i = 1; i < c_n_states; i++) begin
      if (r_pm[i] < w_min_cur) begin
        w_min_cur = r_pm[i];
      end
    end
  end
`else
  assign w_min_cur = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_n_states; i++) begin
        r_pm[i] <= (i == 0) ? '0 : c_init_pm;
      end
      r_out_valid  <= 1'b0;
      r_dec        <= '0;
      r_best_state <= '0;
      r_best_pm    <= '0;
    end else begin
      r_out_valid <= in_valid && !start;
      if (start) begin
        for (int i = 0; i < c_n_states; i++) begin
          r_pm[i] <= (i == 0) ? '0 : c_init_pm;
        end
      end else if (in_valid) begin
        for (int i = 0; i < c_n_states; i++) begin
          r_pm[i] <= w_sel[i] - w_min_cur;
        end
        r_dec        <= w_dec;
        r_best_state <= w_best_st;
        r_best_pm    <= w_best_pm;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign dec_o        = r_dec;
  assign best_state_o = r_best_state;
  assign best_pm_o    = r_best_pm;

endmodule
`default_nettype wire

// File: tb/tb_acs_trellis_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_acs_trellis_array                                          |
// | Purpose  : Self-checking bench for acs_trellis_array (K=3, G=7,5).       |
// |            A forward-trellis reference model predicts each step; the     |
// |            expectations queue up at drive time and are matched when      |
// |            out_valid rises. Follows ACS_NORM_EN like the design.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_acs_trellis_array;
  import viterbi_pkg::*;

  localparam int K       = 3;
  localparam int G0      = 7;
  localparam int G1      = 5;
  localparam int BM_W    = 4;
  localparam int PM_W    = 8;
  localparam int INIT_PM = 32;
  localparam int NS      = 4;
  localparam int PM_MAX  = 255;

  typedef struct {
    logic [NS-1:0]   dec;
    logic [K-2:0]    st;
    logic [PM_W-1:0] pm;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [4*BM_W-1:0] bm_i = '0;
  logic              out_valid;
  logic [NS-1:0]     dec_o;
  logic [K-2:0]      best_state_o;
  logic [PM_W-1:0]   best_pm_o;

  int   n_checks = 0;
  int   n_errs   = 0;
  int   m_pm [NS];
  exp_t q [$];

  acs_trellis_array #(
    .K       (K),
    .G0      (G0),
    .G1      (G1),
    .BM_W    (BM_W),
    .PM_W    (PM_W),
    .INIT_PM (INIT_PM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .bm_i         (bm_i),
    .out_valid    (out_valid),
    .dec_o        (dec_o),
    .best_state_o (best_state_o),
    .best_pm_o    (best_pm_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pm[0] = 0;
    for (int i = 1; i < NS; i++) m_pm[i] = INIT_PM;
  endtask

  // Forward trellis: from state s with input u the register is {u, s}
  // and the next state is {u, s[K-2:1]}; s[0] is the decision bit.
  task automatic model_step(input logic [4*BM_W-1:0] bv, output exp_t e);
    int cand [NS][2];
    int nw [NS];
    int mn, ns, code, c0, c1, j, bi, bpm;
    mn = m_pm[0];
    for (int i = 1; i < NS; i++) if (m_pm[i] < mn) mn = m_pm[i];
    for (int s = 0; s < NS; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns   = (u << (K - 2)) | (s >> 1);
        code = (u << (K - 1)) | s;
        c0   = (^(G0 & code)) ? 1 : 0;
        c1   = (^(G1 & code)) ? 1 : 0;
        j    = 2 * c0 + c1;
        cand[ns][s & 1] = m_pm[s] + int'(bv[j*BM_W +: BM_W]);
        if (cand[ns][s & 1] > PM_MAX) cand[ns][s & 1] = PM_MAX;
      end
    end
    e.dec = '0;
    for (int n = 0; n < NS; n++) begin
      if (cand[n][1] < cand[n][0]) begin
        e.dec[n] = 1'b1;
        nw[n]    = cand[n][1];
      end else begin
        nw[n]    = cand[n][0];
      end
    end
    bi  = 0;
    bpm = nw[0];
    for (int n = 1; n < NS; n++) begin
      if (nw[n] < bpm) begin
        bpm = nw[n];
        bi  = n;
      end
    end
    e.st = 2'(bi);
    e.pm = 8'(bpm);
`ifdef ACS_NORM_EN
    for (int n = 0; n < NS; n++) m_pm[n] = nw[n] - mn;
`else
    for (int n = 0; n < NS; n++) m_pm[n] = nw[n];
`endif
  endtask

  // Drive one step at the falling edge; hand-derived expectations override
  // the model output for the directed cases.
  task automatic step(input logic [4*BM_W-1:0] bv, input bit hand,
                      input logic [NS-1:0] hd, input logic [K-2:0] hs,
                      input logic [PM_W-1:0] hp);
    exp_t e;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    bm_i     = bv;
    model_step(bv, e);
    if (hand) begin
      e.dec = hd;
      e.st  = hs;
      e.pm  = hp;
    end
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic rand_step();
    logic [4*BM_W-1:0] bv;
    bv = 16'($urandom_range(0, 65535));
    step(bv, 1'b0, '0, '0, '0);
  endtask

  // Monitor: out_valid must follow an accepted step by one cycle exactly
  initial begin
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = in_valid && !start && !rst;
      #1;
      chk("out_valid", 32'(out_valid), 32'(v));
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("dec_o", 32'(dec_o), 32'(e.dec));
          chk("best_state", 32'(best_state_o), 32'(e.st));
          chk("best_pm", 32'(best_pm_o), 32'(e.pm));
        end else begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dec", 32'(dec_o), 32'd0);
    chk("rst_best_state", 32'(best_state_o), 32'd0);
    chk("rst_best_pm", 32'(best_pm_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero metrics: ns1/ns3 tie (dec 0), states 0 and 2 tie at 0 (lowest wins)
    step(16'h0000, 1'b1, 4'b0000, 2'd0, 8'd0);
    idle();
    idle();

    // Fresh reset, then bm = {0,2,2,4}
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(16'h4220, 1'b1, 4'b0000, 2'd0, 8'd0);
    for (int i = 0; i < 5; i++) rand_step();

    // start together with in_valid mid-stream: step dropped, metrics reload
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b1;
    bm_i     = 16'h1234;
    model_reset();
    // pm {0,32,32,32}, bm zero: ns1/ns3 tie at 32, ns0/ns2 reach 0
    step(16'h0000, 1'b1, 4'b0000, 2'd0, 8'd0);
    for (int i = 0; i < 3; i++) rand_step();

    // Asynchronous reset between edges while a step is pending
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_dec", 32'(dec_o), 32'd0);
    chk("arst_best_pm", 32'(best_pm_o), 32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    step(16'h0000, 1'b1, 4'b0000, 2'd0, 8'd0);

    // Long back-to-back random stream
    for (int i = 0; i < 200; i++) rand_step();

    // Maximal branch metrics: saturation without wrap-around
    for (int i = 0; i < 20; i++) step(16'hFFFF, 1'b0, '0, '0, '0);
    idle();
    idle();
    idle();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
